// File: rtl/sensor_frame_packer.sv
// Snapshots DHT11/DS18B20 readings, converts them to decimal ASCII and streams one text frame
// over a valid/ready byte interface. Define FRAME_CHK_EN to append a two-digit hex XOR of the frame.
module sensor_frame_packer #(
  parameter int unsigned PERIOD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [39:0]       dht11_data,
  input  logic [11:0]       ds18b20_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              chk_err,
  output logic [7:0]        drop_cnt
);

`ifdef FRAME_CHK_EN
  localparam logic [4:0] LAST_IDX = 5'd22;
`else
  localparam logic [4:0] LAST_IDX = 5'd20;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = (PERIOD_CYCLES == 32'd0) ? '0 : CNT_W'(PERIOD_CYCLES - 32'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, CONV = 2'd2, SEND = 2'd3} state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4:0][29:0]  lane_r;   // per lane: {bcd[15:0], binary[13:0]}
  logic [3:0]        step_r;
  logic [4:0]        idx_r;
  logic [4:0]        sel_idx_s;
  logic [7:0]        byte_s;
  logic [13:0]       frac_s;
  logic              auto_s;
  logic              trig_s;
  logic              xfer_s;
`ifdef FRAME_CHK_EN
  logic [7:0]        xor_r;
  logic [7:0]        xor_s;
`endif

  function automatic logic checksum_ok(input logic [39:0] w);
    logic [7:0] sum;
    sum = w[39:32] + w[31:24] + w[23:16] + w[15:8];
    return (sum == w[7:0]);
  endfunction

  function automatic logic [29:0] dabble(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int d = 0; d < 4; d++) begin
      if (t[14 + 4*d +: 4] >= 4'd5) t[14 + 4*d +: 4] = t[14 + 4*d +: 4] + 4'd3;
      else                          t[14 + 4*d +: 4] = t[14 + 4*d +: 4];
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [7:0] digit(input logic bad, input logic [3:0] d);
    return bad ? 8'h2D : {4'h3, d};
  endfunction

`ifdef FRAME_CHK_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction
`endif

  // Trigger sources and handshake qualifier
  always_comb begin
    auto_s = 1'b0;
    if (PERIOD_CYCLES != 32'd0) auto_s = (cnt_r == CNT_LAST);
    else                        auto_s = 1'b0;
    trig_s = start | auto_s;
    xfer_s = tx_valid & tx_ready;
    frac_s = {10'd0, ds18b20_data[3:0]} * 14'd625;
  end

  // Index of the byte to load next: 0 when entering SEND, else the one after the current byte
  always_comb begin
    sel_idx_s = 5'd0;
    if (state_r == SEND) sel_idx_s = idx_r + 5'd1;
    else                 sel_idx_s = 5'd0;
  end

`ifdef FRAME_CHK_EN
  // XOR including the byte being accepted, frozen once the checksum digits are reached
  always_comb begin
    xor_s = xor_r;
    if (idx_r < 5'd19) xor_s = xor_r ^ tx_data;
    else               xor_s = xor_r;
  end
`endif

  // Frame byte lookup from the converted BCD lanes
  always_comb begin
    byte_s = 8'h00;
    case (sel_idx_s)
      5'd0:  byte_s = 8'h48;
      5'd1:  byte_s = digit(chk_err, lane_r[0][25:22]);
      5'd2:  byte_s = digit(chk_err, lane_r[0][21:18]);
      5'd3:  byte_s = digit(chk_err, lane_r[0][17:14]);
      5'd4:  byte_s = 8'h54;
      5'd5:  byte_s = digit(chk_err, lane_r[1][25:22]);
      5'd6:  byte_s = digit(chk_err, lane_r[1][21:18]);
      5'd7:  byte_s = digit(chk_err, lane_r[1][17:14]);
      5'd8:  byte_s = 8'h2E;
      5'd9:  byte_s = digit(chk_err, lane_r[4][17:14]);
      5'd10: byte_s = 8'h44;
      5'd11: byte_s = digit(1'b0, lane_r[2][25:22]);
      5'd12: byte_s = digit(1'b0, lane_r[2][21:18]);
      5'd13: byte_s = digit(1'b0, lane_r[2][17:14]);
      5'd14: byte_s = 8'h2E;
      5'd15: byte_s = digit(1'b0, lane_r[3][29:26]);
      5'd16: byte_s = digit(1'b0, lane_r[3][25:22]);
      5'd17: byte_s = digit(1'b0, lane_r[3][21:18]);
      5'd18: byte_s = digit(1'b0, lane_r[3][17:14]);
`ifdef FRAME_CHK_EN
      5'd19: byte_s = hex_ascii(xor_s[7:4]);
      5'd20: byte_s = hex_ascii(xor_s[3:0]);
      5'd21: byte_s = 8'h0D;
      5'd22: byte_s = 8'h0A;
`else
      5'd19: byte_s = 8'h0D;
      5'd20: byte_s = 8'h0A;
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // Free-running period counter, independent of the frame state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_r <= '0;
    else if (PERIOD_CYCLES == 32'd0)  cnt_r <= '0;
    else if (auto_s)                  cnt_r <= '0;
    else                              cnt_r <= cnt_r + CNT_W'(1);
  end

  // Saturating count of triggers that arrive while a frame is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  drop_cnt <= 8'd0;
    else if (trig_s && state_r != IDLE && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    else                                                      drop_cnt <= drop_cnt;
  end

  // Frame sequencer: capture, five parallel 14-step double-dabble lanes, then byte streaming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      lane_r   <= '0;
      step_r   <= 4'd0;
      idx_r    <= 5'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      chk_err  <= 1'b0;
`ifdef FRAME_CHK_EN
      xor_r    <= 8'h00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            state_r <= LATCH;
            busy    <= 1'b1;
          end
        end
        LATCH: begin
          chk_err   <= ~checksum_ok(dht11_data);
          lane_r[0] <= {22'd0, dht11_data[39:32]};
          lane_r[1] <= {22'd0, dht11_data[23:16]};
          lane_r[2] <= {22'd0, ds18b20_data[11:4]};
          lane_r[3] <= {16'd0, frac_s};
          lane_r[4] <= {22'd0, dht11_data[15:8]};
          step_r    <= 4'd0;
          state_r   <= CONV;
        end
        CONV: begin
          for (int k = 0; k < 5; k++) lane_r[k] <= dabble(lane_r[k]);
          step_r <= step_r + 4'd1;
          if (step_r == 4'd13) begin
            state_r  <= SEND;
            idx_r    <= 5'd0;
            tx_data  <= byte_s;
            tx_valid <= 1'b1;
`ifdef FRAME_CHK_EN
            xor_r    <= 8'h00;
`endif
          end
        end
        SEND: begin
          if (xfer_s) begin
            if (idx_r == LAST_IDX) begin
              state_r  <= IDLE;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              busy     <= 1'b0;
            end else begin
              idx_r   <= idx_r + 5'd1;
              tx_data <= byte_s;
`ifdef FRAME_CHK_EN
              xor_r   <= xor_s;
`endif
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
